board_test_button_reader: RTL

- Input-side counterpart to the board LED drivers. Samples the raw active-low push buttons s1/s2 on the internal oscillator clock.
- Each button gets its own 2-FF synchronizer and debounce state machine.
- Produces a clean level plus single-cycle press, release and long-press events for board-test logic. These events replace direct use of s1/s2 as logic inputs.

---
 rtl/board_test_button_pkg.sv | 17 +
 rtl/board_test_button_debounce.sv | 162 ++++++++++++++++
 rtl/board_test_button_reader.sv | 36 +++
 3 files changed

// File: rtl/board_test_button_pkg.sv
// Shared types and sizing helpers for the board-test button reader.
package board_test_button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } btn_state_e;

    function automatic int cnt_width(input int long_c, input int rep_c);
        int m;
        m = (long_c > rep_c) ? long_c : rep_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/board_test_button_debounce.sv
// One button channel: 2-FF synchronizer, debounce FSM, hold/long-press timing.
// Auto-repeat presses after long_press when BOARD_TEST_BUTTON_REPEAT_EN is defined.
module board_test_button_debounce
    import board_test_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 2500000,
    parameter int REPEAT_CYCLES   = 500000
) (
    input  logic int_clock,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic release_evt,
    output logic long_press
);

    localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [1:0]    sync_ff;
    logic          sync;
    btn_state_e    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;

    always_ff @(posedge int_clock or negedge rst) begin
        if (!rst) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], btn_n};
        end
    end

    assign sync = ~sync_ff[1];

`ifdef BOARD_TEST_BUTTON_REPEAT_EN
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

    logic          rpt_on;
    logic [CW-1:0] rpt;
    logic          releasing;

    // A repeat that lands on the release cycle is dropped to keep events exclusive.
    assign releasing = !sync &&
        ((state == DEB_RELEASE && rcnt == DEB_LAST) ||
         (state == PRESSED && DEBOUNCE_CYCLES == 1));
`endif

    always_ff @(posedge int_clock or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rcnt        <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
`ifdef BOARD_TEST_BUTTON_REPEAT_EN
            rpt_on      <= 1'b0;
            rpt         <= '0;
`endif
        end else begin
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            unique case (state)
                IDLE: begin
                    level <= 1'b0;
                    if (sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= PRESSED;
                            level <= 1'b1;
                            press <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= DEB_PRESS;
                            cnt   <= ONE;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= PRESSED;
                        level <= 1'b1;
                        press <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                PRESSED: begin
                    level <= 1'b1;
                    if (!sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state       <= IDLE;
                            level       <= 1'b0;
                            release_evt <= 1'b1;
                            cnt         <= '0;
                            rcnt        <= '0;
                        end else begin
                            state <= DEB_RELEASE;
                            rcnt  <= ONE;
                        end
                    end else if (cnt != LONG_MAX) begin
                        cnt <= cnt + ONE;
                        if (cnt == LONG_LAST) begin
                            long_press <= 1'b1;
                        end
                    end
                end
                DEB_RELEASE: begin
                    level <= 1'b1;
                    if (sync) begin
                        state <= PRESSED;
                        rcnt  <= '0;
                    end else if (rcnt == DEB_LAST) begin
                        state       <= IDLE;
                        level       <= 1'b0;
                        release_evt <= 1'b1;
                        cnt         <= '0;
                        rcnt        <= '0;
                    end else begin
                        rcnt <= rcnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef BOARD_TEST_BUTTON_REPEAT_EN
            if (state == PRESSED || state == DEB_RELEASE) begin
                if (rpt_on) begin
                    if (rpt == RPT_LAST) begin
                        rpt <= '0;
                        if (!releasing) begin
                            press <= 1'b1;
                        end
                    end else begin
                        rpt <= rpt + ONE;
                    end
                end
                if (state == PRESSED && sync && cnt == LONG_LAST) begin
                    rpt_on <= 1'b1;
                    rpt    <= '0;
                end
            end else begin
                rpt_on <= 1'b0;
                rpt    <= '0;
            end
`endif
        end
    end

endmodule

// File: rtl/board_test_button_reader.sv
// Debounced push-button reader: level plus press/release/long-press pulses.
// Optional auto-repeat: define BOARD_TEST_BUTTON_REPEAT_EN.
module board_test_button_reader
    import board_test_button_pkg::*;
#(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 2500000,
    parameter int REPEAT_CYCLES   = 500000
) (
    input  logic                 int_clock,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_n,
    output logic [N_BUTTONS-1:0] level,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] release_evt,
    output logic [N_BUTTONS-1:0] long_press
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        board_test_button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_deb (
            .int_clock  (int_clock),
            .rst        (rst),
            .btn_n      (btn_n[i]),
            .level      (level[i]),
            .press      (press[i]),
            .release_evt(release_evt[i]),
            .long_press (long_press[i])
        );
    end

endmodule
